// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//   Releases a bank of active-low channel resets one at a time, in ascending
//   index order, once the PLL has been stably locked and a hold-off delay has
//   elapsed. Loss of lock or a software reset request drops every channel
//   back into reset together and restarts the whole sequence.
//
// Ports
//   i_clk           : single clock for all sequential logic
//   i_reset_n       : asynchronous active-low reset (deassertion synchronized)
//   i_pll_locked    : asynchronous lock indicator (double-flop synchronized)
//   i_sw_reset      : synchronous active-high request for a full re-sequence
//   o_chan_reset_n  : per-channel active-low resets, released low index first
//   o_all_released  : high once every channel has been released
//   o_seq_state     : 0 = LOCK_WAIT, 1 = DELAY, 2 = RELEASE, 3 = DONE
// ---------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NUM_CHANNELS = 4,
  parameter int DELAY_CYCLES = 160,
  parameter int STAGE_GAP    = 16,
  parameter int LOCK_FILTER  = 8,
  parameter int USE_LOCK     = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_pll_locked,
  input  logic                    i_sw_reset,
  output logic [NUM_CHANNELS-1:0] o_chan_reset_n,
  output logic                    o_all_released,
  output logic [1:0]              o_seq_state
);

  // Counter widths are derived from each counter's terminal value.
  localparam int LOCK_W  = $clog2(LOCK_FILTER - 1) + 1;
  localparam int DELAY_W = $clog2(DELAY_CYCLES - 1) + 1;
  localparam int GAP_W   = $clog2(STAGE_GAP - 1) + 1;
  localparam int CH_W    = $clog2(NUM_CHANNELS - 1) + 1;

  localparam logic [LOCK_W-1:0]       LOCK_TERM  = LOCK_W'(LOCK_FILTER - 1);
  localparam logic [DELAY_W-1:0]      DELAY_TERM = DELAY_W'(DELAY_CYCLES - 1);
  localparam logic [GAP_W-1:0]        GAP_TERM   = GAP_W'(STAGE_GAP - 1);
  localparam logic [CH_W-1:0]         CH_LAST    = CH_W'(NUM_CHANNELS - 1);
  localparam logic [NUM_CHANNELS-1:0] CH_ONE     = NUM_CHANNELS'(1'b1);
  localparam logic                    LOCK_BYPASS = (USE_LOCK == 0);

  typedef enum logic [1:0] {
    ST_LOCK_WAIT = 2'd0,
    ST_DELAY     = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  logic [1:0]              r_rst_sync;
  logic [1:0]              r_lock_sync;
  state_t                  r_state;
  logic [LOCK_W-1:0]       r_lock_cnt;
  logic [DELAY_W-1:0]      r_dly_cnt;
  logic [GAP_W-1:0]        r_gap_cnt;
  logic [CH_W-1:0]         r_ch_idx;
  logic [NUM_CHANNELS-1:0] r_chan;
  logic                    r_all;

  logic                    w_rst_i_n;
  logic                    w_locked_s;
  logic                    w_abort;
  logic [NUM_CHANNELS-1:0] w_ch_mask;
  state_t                  w_state_nxt;
  logic [LOCK_W-1:0]       w_lock_cnt_nxt;
  logic [DELAY_W-1:0]      w_dly_cnt_nxt;
  logic [GAP_W-1:0]        w_gap_cnt_nxt;
  logic [CH_W-1:0]         w_ch_idx_nxt;
  logic [NUM_CHANNELS-1:0] w_chan_nxt;
  logic                    w_all_nxt;

  // Reset synchronizer: assertion is immediate, release happens on the 2nd edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_i_n = r_rst_sync[1];

  // Lock synchronizer: runs straight from i_reset_n so it is already sampling
  // while the internal reset is still being held.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lock_sync <= 2'b00;
    end else begin
      r_lock_sync <= {r_lock_sync[0], i_pll_locked};
    end
  end

  // With the lock check disabled the synchronized lock is forced high, so only
  // a software reset can abort the sequence.
  assign w_locked_s = r_lock_sync[1] | LOCK_BYPASS;
  assign w_abort    = (~w_locked_s) | i_sw_reset;
  assign w_ch_mask  = CH_ONE << r_ch_idx;

  // Next-state, counter and output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_dly_cnt_nxt  = r_dly_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_ch_idx_nxt   = r_ch_idx;
    w_chan_nxt     = r_chan;
    w_all_nxt      = r_all;

    case (r_state)
      ST_LOCK_WAIT: begin
        if (w_locked_s && !i_sw_reset) begin
          if (r_lock_cnt == LOCK_TERM) begin
            w_state_nxt    = ST_DELAY;
            w_lock_cnt_nxt = '0;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1'b1);
          end
        end else begin
          w_lock_cnt_nxt = '0;
        end
      end

      ST_DELAY: begin
        // Abort is tested first so it beats the terminal count on the same edge.
        if (w_abort) begin
          w_state_nxt    = ST_LOCK_WAIT;
          w_lock_cnt_nxt = '0;
          w_dly_cnt_nxt  = '0;
          w_gap_cnt_nxt  = '0;
          w_ch_idx_nxt   = '0;
          w_chan_nxt     = '0;
          w_all_nxt      = 1'b0;
        end else if (r_dly_cnt == DELAY_TERM) begin
          w_dly_cnt_nxt = '0;
          w_chan_nxt    = CH_ONE;
          if (NUM_CHANNELS == 1) begin
            // A single channel needs no stage gap: finish on this edge.
            w_state_nxt = ST_DONE;
            w_all_nxt   = 1'b1;
          end else begin
            w_state_nxt  = ST_RELEASE;
            w_ch_idx_nxt = CH_W'(1'b1);
          end
        end else begin
          w_dly_cnt_nxt = r_dly_cnt + DELAY_W'(1'b1);
        end
      end

      ST_RELEASE: begin
        if (w_abort) begin
          w_state_nxt    = ST_LOCK_WAIT;
          w_lock_cnt_nxt = '0;
          w_dly_cnt_nxt  = '0;
          w_gap_cnt_nxt  = '0;
          w_ch_idx_nxt   = '0;
          w_chan_nxt     = '0;
          w_all_nxt      = 1'b0;
        end else if (r_gap_cnt == GAP_TERM) begin
          // r_ch_idx always names the next channel still held in reset.
          w_gap_cnt_nxt = '0;
          w_chan_nxt    = r_chan | w_ch_mask;
          if (r_ch_idx == CH_LAST) begin
            w_state_nxt = ST_DONE;
            w_all_nxt   = 1'b1;
          end else begin
            w_ch_idx_nxt = r_ch_idx + CH_W'(1'b1);
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1'b1);
        end
      end

      ST_DONE: begin
        if (w_abort) begin
          w_state_nxt    = ST_LOCK_WAIT;
          w_lock_cnt_nxt = '0;
          w_dly_cnt_nxt  = '0;
          w_gap_cnt_nxt  = '0;
          w_ch_idx_nxt   = '0;
          w_chan_nxt     = '0;
          w_all_nxt      = 1'b0;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end

      default: begin
        w_state_nxt    = ST_LOCK_WAIT;
        w_lock_cnt_nxt = '0;
        w_dly_cnt_nxt  = '0;
        w_gap_cnt_nxt  = '0;
        w_ch_idx_nxt   = '0;
        w_chan_nxt     = '0;
        w_all_nxt      = 1'b0;
      end
    endcase
  end

  // FSM, counters and output registers, all cleared by the internal reset.
  always_ff @(posedge i_clk or negedge w_rst_i_n) begin
    if (!w_rst_i_n) begin
      r_state    <= ST_LOCK_WAIT;
      r_lock_cnt <= '0;
      r_dly_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_ch_idx   <= '0;
      r_chan     <= '0;
      r_all      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_dly_cnt  <= w_dly_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_ch_idx   <= w_ch_idx_nxt;
      r_chan     <= w_chan_nxt;
      r_all      <= w_all_nxt;
    end
  end

  assign o_chan_reset_n = r_chan;
  assign o_all_released = r_all;
  assign o_seq_state    = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//   Scoreboard bench for reset_sequencer. Stimulus pushes expected output
//   snapshots tagged with the clock edge they belong to; a monitor on the
//   falling edge pops and compares every entry whose edge has arrived.
//   dut0 uses the lock input, dut1 ignores it (pll_locked tied low).
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

  logic       clk;
  logic       reset_n;
  logic       reset_n2;
  logic       pll_locked;
  logic       sw_reset;
  logic [2:0] chan0;
  logic       all0;
  logic [1:0] st0;
  logic [2:0] chan1;
  logic       all1;
  logic [1:0] st1;

  int edge_cnt;
  int checks;
  int errors;

  typedef struct {
    int         cyc;
    int         dut;
    logic [2:0] chan;
    logic       all;
    logic [1:0] st;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [2:0] act_chan;
  logic       act_all;
  logic [1:0] act_st;

  reset_sequencer #(
    .NUM_CHANNELS(3), .DELAY_CYCLES(4), .STAGE_GAP(2), .LOCK_FILTER(3), .USE_LOCK(1)
  ) dut0 (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_pll_locked   (pll_locked),
    .i_sw_reset     (sw_reset),
    .o_chan_reset_n (chan0),
    .o_all_released (all0),
    .o_seq_state    (st0)
  );

  reset_sequencer #(
    .NUM_CHANNELS(3), .DELAY_CYCLES(4), .STAGE_GAP(2), .LOCK_FILTER(3), .USE_LOCK(0)
  ) dut1 (
    .i_clk          (clk),
    .i_reset_n      (reset_n2),
    .i_pll_locked   (1'b0),
    .i_sw_reset     (1'b0),
    .o_chan_reset_n (chan1),
    .o_all_released (all1),
    .o_seq_state    (st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Keep the queue ordered by target edge so the monitor can pop from the front.
  task automatic push_exp(input int cyc, input int dut, input logic [2:0] chan,
                          input logic all, input logic [1:0] st, input string name);
    exp_t e;
    int   pos;
    e.cyc = cyc; e.dut = dut; e.chan = chan; e.all = all; e.st = st; e.name = name;
    pos = sb_q.size();
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc > cyc) pos = i;
    end
    sb_q.insert(pos, e);
  endtask

  // Expected timeline after reset release / relock; base is edge E0.
  task automatic nominal(input int base, input int dut, input string tag);
    push_exp(base + 4,  dut, 3'b000, 1'b0, 2'd0, {tag, "_E4"});
    push_exp(base + 5,  dut, 3'b000, 1'b0, 2'd1, {tag, "_E5"});
    push_exp(base + 8,  dut, 3'b000, 1'b0, 2'd1, {tag, "_E8"});
    push_exp(base + 9,  dut, 3'b001, 1'b0, 2'd2, {tag, "_E9"});
    push_exp(base + 10, dut, 3'b001, 1'b0, 2'd2, {tag, "_E10"});
    push_exp(base + 11, dut, 3'b011, 1'b0, 2'd2, {tag, "_E11"});
    push_exp(base + 12, dut, 3'b011, 1'b0, 2'd2, {tag, "_E12"});
    push_exp(base + 13, dut, 3'b111, 1'b1, 2'd3, {tag, "_E13"});
    push_exp(base + 14, dut, 3'b111, 1'b1, 2'd3, {tag, "_E14"});
  endtask

  task automatic wait_until(input int c);
    while (edge_cnt < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation whose edge has been reached.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (mon_e.dut == 0) begin
        act_chan = chan0; act_all = all0; act_st = st0;
      end else begin
        act_chan = chan1; act_all = all1; act_st = st1;
      end
      if (mon_e.cyc < edge_cnt) begin
        errors++;
        $display("FAIL %s: check missed at edge %0d, required edge %0d",
                 mon_e.name, edge_cnt, mon_e.cyc);
      end else if (act_chan !== mon_e.chan || act_all !== mon_e.all || act_st !== mon_e.st) begin
        errors++;
        $display("FAIL %s: got chan=%b all=%b st=%0d, expected chan=%b all=%b st=%0d",
                 mon_e.name, act_chan, act_all, act_st, mon_e.chan, mon_e.all, mon_e.st);
      end
    end
  end

  // Watchdog bounds the whole run.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at edge %0d, expected completion earlier", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  int base;
  int c;
  int a;

  initial begin
    reset_n    = 1'b1;
    reset_n2   = 1'b1;
    pll_locked = 1'b1;
    sw_reset   = 1'b0;
    #1;
    reset_n  = 1'b0;
    reset_n2 = 1'b0;

    // Reset state for both instances while clock is running.
    wait_until(3);
    push_exp(edge_cnt, 0, 3'b000, 1'b0, 2'd0, "reset_dut0");
    push_exp(edge_cnt, 1, 3'b000, 1'b0, 2'd0, "reset_dut1");
    wait_until(4);

    // Nominal sequence.
    reset_n = 1'b1;
    base = edge_cnt;
    nominal(base, 0, "nom");
    wait_until(base + 14);

    // Lock loss in DONE: lock drops before edge c+1, abort seen at c+3.
    pll_locked = 1'b0;
    c = edge_cnt;
    push_exp(c + 2, 0, 3'b111, 1'b1, 2'd3, "loss_hold");
    push_exp(c + 3, 0, 3'b000, 1'b0, 2'd0, "loss_abort");
    wait_until(c + 3);

    // Relock re-runs the full timeline from the next edge.
    pll_locked = 1'b1;
    base = edge_cnt;
    nominal(base, 0, "relock");
    wait_until(base + 14);

    // sw_reset from DONE, then a one-edge lock glitch while lock_cnt is 2.
    sw_reset = 1'b1;
    c = edge_cnt;
    wait_until(c + 1);
    sw_reset   = 1'b0;
    pll_locked = 1'b0;
    a = edge_cnt;
    push_exp(a, 0, 3'b000, 1'b0, 2'd0, "sw_abort_done");
    wait_until(a + 1);
    pll_locked = 1'b1;
    push_exp(a + 3,  0, 3'b000, 1'b0, 2'd0, "glitch_clear");
    push_exp(a + 5,  0, 3'b000, 1'b0, 2'd0, "glitch_wait");
    push_exp(a + 6,  0, 3'b000, 1'b0, 2'd1, "glitch_delay");
    push_exp(a + 10, 0, 3'b001, 1'b0, 2'd2, "glitch_rel0");
    push_exp(a + 11, 0, 3'b001, 1'b0, 2'd2, "pre_ch1");

    // sw_reset coincident with the channel-1 release edge: abort wins.
    wait_until(a + 11);
    sw_reset = 1'b1;
    push_exp(a + 12, 0, 3'b000, 1'b0, 2'd0, "sw_vs_ch1");
    wait_until(a + 12);
    sw_reset = 1'b0;
    push_exp(a + 15, 0, 3'b000, 1'b0, 2'd1, "recover_delay");
    push_exp(a + 19, 0, 3'b001, 1'b0, 2'd2, "recover_rel0");
    push_exp(a + 23, 0, 3'b111, 1'b1, 2'd3, "recover_done");
    wait_until(a + 24);

    // Async reset between edges in DONE: checked before the next posedge.
    reset_n = 1'b0;
    push_exp(edge_cnt, 0, 3'b000, 1'b0, 2'd0, "async_rst");
    c = edge_cnt;
    wait_until(c + 2);
    push_exp(edge_cnt, 0, 3'b000, 1'b0, 2'd0, "async_rst_hold");
    wait_until(c + 3);
    reset_n = 1'b1;
    base = edge_cnt;
    nominal(base, 0, "rerun");
    wait_until(base + 14);

    // Lock ignored: pll_locked tied low, same timeline.
    reset_n2 = 1'b1;
    base = edge_cnt;
    nominal(base, 1, "nolock");
    wait_until(base + 16);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expectations unchecked, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of sequenced reset outputs; legal range 1..16.
REQ-002 Parameter DELAY_CYCLES, default 160: hold cycles after lock qualification before the first release; legal range >= 1.
REQ-003 Parameter STAGE_GAP, default 16: cycles between successive channel releases; legal range >= 1.
REQ-004 Parameter LOCK_FILTER, default 8: consecutive synchronized-locked cycles required; legal range >= 1.
REQ-005 Parameter USE_LOCK, default 1: 1 means pll_locked gates the sequence; 0 means pll_locked is ignored and treated as 1.
REQ-006 clk  input  1  single clock for all sequential logic.
REQ-007 reset_n  input  1  asynchronous, active-low reset; assertion is asynchronous, and deassertion takes effect internally only after synchronization.
REQ-008 pll_locked  input  1  asynchronous lock indicator; double-flop synchronized internally to locked_s.
REQ-009 sw_reset  input  1  synchronous to clk, active-high; requests a full re-sequence.
REQ-010 chan_reset_n  output  NUM_CHANNELS  active-low reset per channel, released in ascending index order.
REQ-011 all_released  output  1  high when every channel is released.
REQ-012 seq_state  output  2  current FSM state: 0 = LOCK_WAIT, 1 = DELAY, 2 = RELEASE, 3 = DONE.

Function
REQ-013 The reset synchronizer SHALL be two flops, asynchronously cleared by reset_n, with a 1 shifted in; the internal reset rst_i is released after the 2nd posedge following reset_n deassertion.
REQ-014 The lock synchronizer SHALL be two flops, asynchronously cleared by reset_n, and SHALL run from the 1st posedge after reset_n deassertion.
REQ-015 All FSM, counter and output flops SHALL be asynchronously reset by rst_i.
REQ-016 Counters SHALL each be sized $clog2(max terminal value)+1 bits; none may wrap in legal operation.
REQ-017 In LOCK_WAIT, lock_cnt SHALL increment on each edge with locked_s=1 and clear on locked_s=0 or sw_reset=1; an edge with locked_s=1 and lock_cnt==LOCK_FILTER-1 SHALL move the FSM to DELAY and clear the counter.
REQ-018 In DELAY, dly_cnt SHALL increment each edge; the edge with dly_cnt==DELAY_CYCLES-1 SHALL move the FSM to RELEASE, set chan_reset_n[0]=1 and clear dly_cnt.
REQ-019 In RELEASE, gap_cnt SHALL increment each edge; the edge with gap_cnt==STAGE_GAP-1 SHALL set the next channel's bit, clear gap_cnt, and advance the channel index.
REQ-020 The edge that releases channel NUM_CHANNELS-1 SHALL move the FSM to DONE and set all_released=1 on that same edge.
REQ-021 With NUM_CHANNELS=1, the RELEASE state SHALL be skipped; the DELAY terminal edge SHALL go directly to DONE, with chan_reset_n[0]=1 and all_released=1.
REQ-022 Abort: in DELAY, RELEASE or DONE, an edge with locked_s=0 or sw_reset=1 SHALL clear all chan_reset_n bits, all_released and all counters, and move the FSM to LOCK_WAIT.
REQ-023 Abort SHALL take priority over every terminal-count transition on the same edge.
REQ-024 Released channels SHALL never re-assert individually; assertion is always all channels together.
REQ-025 When USE_LOCK=0, locked_s SHALL be forced to 1, so only sw_reset aborts.

Reset
REQ-026 While reset_n=0: chan_reset_n=all 0, all_released=0, seq_state=0, all counters 0, and both synchronizers 0, all independent of clk.
REQ-027 Assertion of reset_n mid-sequence SHALL immediately force the REQ-026 values, with no glitch-high on any chan_reset_n bit.
REQ-028 No initial blocks SHALL be used; reset values come only from reset_n.

Verification
Bench parameters: NUM_CHANNELS=3, DELAY_CYCLES=4, STAGE_GAP=2, LOCK_FILTER=3, USE_LOCK=1. E1 is the first posedge after reset_n rises.
REQ-029 Nominal: pll_locked=1 throughout -> seq_state=1 at E5, seq_state=2 and chan_reset_n=3'b001 at E9, 3'b011 at E11, 3'b111 with all_released=1 and seq_state=3 at E13.
REQ-030 Lock loss in DONE: pll_locked falls before edge Ek -> chan_reset_n=3'b000, all_released=0, seq_state=0 at Ek+2; relock re-runs the full REQ-029 timing.
REQ-031 Lock glitch: pll_locked low for 1 cycle during LOCK_WAIT when lock_cnt=2 -> lock_cnt clears; DELAY is entered only after 3 further consecutive locked_s=1 edges.
REQ-032 sw_reset pulse in RELEASE, coincident with the channel-1 release edge -> chan_reset_n=3'b000 on that edge (abort wins), and seq_state=0.
REQ-033 Async reset: reset_n asserted between edges in DONE -> all outputs 0 before the next posedge; deassertion repeats the REQ-029 timeline from a new E1.
REQ-034 USE_LOCK=0, with pll_locked tied 0 -> sequence completes with the same E5/E9/E13 timing as REQ-029.
